// File: rtl/byte_ram_ctrl.sv
// Byte-addressed big-endian data RAM behind a valid/ready request/response port.
// Configurable width, depth and access latency; per-byte enables, bounds errors, saturating error count.
module byte_ram_ctrl #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [ADDR_W-1:0]     i_req_addr,
    input  logic [DATA_W-1:0]     i_req_wdata,
    input  logic [DATA_W/8-1:0]   i_req_be,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_W-1:0]     o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic [7:0]            o_err_count
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    // Highest legal start address: the whole word must fit, no wrap-around.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - NB);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_accept;
    logic                w_access;
    logic                w_rsp_done;

    logic                r_req_ready;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [NB-1:0]       r_be;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [7:0]          r_err_count;

    logic                w_oob;
    logic [IDX_W-1:0]    w_base;
    logic [DATA_W-1:0]   w_rd_word;

    // Storage is zero at power-up only; reset never touches it.
    logic [7:0]          r_mem [DEPTH] = '{default: 8'h00};

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = (r_state == S_RESP);
    assign o_rsp_rdata = r_rdata;
    assign o_rsp_err   = r_err;
    assign o_err_count = r_err_count;

    // Full-width compare so high address bits never alias into the array.
    assign w_oob  = (r_addr > LAST_ADDR);
    assign w_base = r_addr[IDX_W-1:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_access     = 1'b0;
        w_rsp_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid && r_req_ready) begin
                    w_accept     = 1'b1;
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_access     = 1'b1;
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    w_rsp_done   = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NB; i++) begin
            w_rd_word[DATA_W-1-8*i -: 8] = r_mem[w_base + IDX_W'(i)];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_req_ready <= 1'b0;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            // Registered so ready stays low for the first cycle after reset.
            r_req_ready <= (w_next_state == S_IDLE);
            if (w_accept) begin
                r_we    <= i_req_we;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
                r_be    <= i_req_be;
                r_cnt   <= CNT_W'(LATENCY - 1);
            end else if (r_state == S_WAIT && !w_access) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_access) begin
                r_err   <= w_oob;
                r_rdata <= (!r_we && !w_oob) ? w_rd_word : '0;
                if (w_oob && r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end else if (w_rsp_done) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_access && r_we && !w_oob && !i_rst) begin
            for (int i = 0; i < NB; i++) begin
                if (r_be[NB-1-i]) begin
                    r_mem[w_base + IDX_W'(i)] <= r_wdata[DATA_W-1-8*i -: 8];
                end
            end
        end
    end

endmodule
